pic_scale_engine: RTL
=====================

PIC_SCALE_ENGINE -- requirements
Module: pic_scale_engine

Interface
REQ-001 Parameter FB_W, default 256: framebuffer edge in pixels; power of two, 4 to 512.
REQ-002 Parameter ADDR_W, default 20: memory address width.
REQ-003 Parameter PIX_W, default 24: pixel width; three equal channels of PIX_W/3 bits.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request; sampled only in IDLE.
REQ-007 abort  in  1  synchronous cancel of the current job.
REQ-008 pic_size  in  3  one-hot source size: 001 = FB_W/2, 010 = FB_W, 100 = 2*FB_W; sampled at start.
REQ-009 phase  in  1  0 = write even framebuffer rows, 1 = write odd rows; sampled at start.
REQ-010 pic_base, fb_base  in  ADDR_W  source and framebuffer base addresses; sampled at start.
REQ-011 im_a  out  ADDR_W  memory address.
REQ-012 im_q  in  PIX_W  read data, valid one cycle after a read address.
REQ-013 im_d  out  PIX_W  write data.
REQ-014 im_wen  out  1  active-low write enable; 1 = read.
REQ-015 busy, done, err  out  1 each  job active; one-cycle completion pulse; one-cycle illegal-size pulse.

Function
REQ-016 The FSM SHALL have states IDLE, RD, ACC, WR, FIN; start in IDLE moves to RD on the next edge and sets busy.
REQ-017 Address arithmetic SHALL be base + row*edge + col, truncated modulo 2^ADDR_W.
REQ-018 Copy mode (010) SHALL cover each framebuffer pixel (x,y) with y parity == phase as: read src(x,y), then write it next cycle; 2 cycles per pixel.
REQ-019 Upscale mode (001) SHALL cover each source pixel (sx,sy) as: read; write fb(2sx,2sy+phase); write fb(2sx+1,2sy+phase) from a registered copy; 3 cycles per source pixel.
REQ-020 Downscale mode (100) SHALL cover each fb pixel (x,y) with y parity == phase as: 4 reads src(2x,2y), (2x+1,2y), (2x,2y+1), (2x+1,2y+1), then 1 write; 5 cycles per pixel.
REQ-021 The downscale channel value SHALL be (sum of 4 + 2) >> 2, with a sum width of PIX_W/3+2 and no saturation required.
REQ-022 Traversal order SHALL be row-major, columns innermost, ascending.
REQ-023 Outside a write cycle, im_wen SHALL be 1 and im_d SHALL be 0.
REQ-024 done SHALL pulse in the cycle after the last write; busy SHALL drop in the same cycle; the FSM SHALL return to IDLE.
REQ-025 A non-one-hot pic_size at start SHALL pulse err and done together in the next cycle, perform no writes, and leave busy low.
REQ-026 start while busy SHALL be ignored.
REQ-027 abort SHALL force IDLE on the next edge with no done pulse; a write already presented in that cycle completes.
REQ-028 abort and start together in IDLE: abort wins, so no job starts.
REQ-029 Changes to pic_size, phase or the base inputs during a job SHALL have no effect.

Reset
REQ-030 While reset is low, the FSM SHALL be in IDLE; busy, done and err SHALL be 0; im_wen SHALL be 1; im_a and im_d SHALL be 0; all counters and accumulators SHALL be 0.
REQ-031 Reset asserted mid-job SHALL discard the job; after release, only a new start begins a job.

Structure
REQ-032 Package dpa_pkg SHALL hold the pic_size one-hot encodings, the FSM state enum and the mode codes.
REQ-033 Four-pixel per-channel rounding-average logic SHALL be the sub-module pix_avg4; counters and the FSM stay in pic_scale_engine.

Verification (FB_W = 4, start asserted at cycle 0)
REQ-034 Copy: pic_size=010, phase=0, pic_base=0x100, fb_base=0x000 -> 8 writes to addresses 0-3 and 8-11 with source data; done at cycle 17.
REQ-035 Upscale: pic_size=001, phase=1, src 2x2 = {A,B,C,D} -> writes 4:A, 5:A, 6:B, 7:B, 12:C, 13:C, 14:D, 15:D; done at cycle 13.
REQ-036 Downscale: pic_size=100, phase=0, first 2x2 block channel values 1, 2, 2, 2 -> written channel value 2 (7+2 >> 2); all-0xFF block -> 0xFF; done at cycle 41.
REQ-037 pic_size=011 -> err=1 and done=1 at cycle 1, no writes, busy stays 0.
REQ-038 abort at cycle 5 of a copy job -> no writes after cycle 5, no done pulse, IDLE at cycle 6; start at cycle 7 is accepted.
REQ-039 reset low at cycle 6 -> all outputs at reset values immediately; second start pulse while busy -> ignored, done count stays 1.

Source files
------------

// File: rtl/dpa_pkg.sv
// dpa_pkg: shared encodings for the picture scale engine
package dpa_pkg;
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_FULL = 3'b010;
  localparam logic [2:0] SIZE_DBL = 3'b100;
  typedef enum logic [2:0] {IDLE, RD, ACC, WR, FIN} state_t;
  typedef enum logic [1:0] {MODE_COPY, MODE_UP, MODE_DOWN} mode_t;
endpackage

// File: rtl/pic_scale_engine_if.sv
// pic_scale_engine_if: single-port pixel memory bus
interface pic_scale_engine_if #(parameter int ADDR_W = 20, parameter int PIX_W = 24);
  logic [ADDR_W-1:0] im_a;
  logic [PIX_W-1:0] im_q;
  logic [PIX_W-1:0] im_d;
  logic im_wen;
  modport master(output im_a, output im_d, output im_wen, input im_q);
  modport slave(input im_a, input im_d, input im_wen, output im_q);
endinterface

// File: rtl/pix_avg4.sv
// pix_avg4: per-channel rounded mean of four pixels
module pix_avg4 #(parameter int PIX_W = 24) (
  input logic [PIX_W-1:0] a,
  input logic [PIX_W-1:0] b,
  input logic [PIX_W-1:0] c,
  input logic [PIX_W-1:0] d,
  output logic [PIX_W-1:0] y
);
  localparam int CW = PIX_W / 3;
  // two extra sum bits hold four maxed channels plus the rounding term
  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [CW+1:0] s;
    assign s = {2'b0, a[i*CW+:CW]} + {2'b0, b[i*CW+:CW]} + {2'b0, c[i*CW+:CW]}
             + {2'b0, d[i*CW+:CW]} + (CW+2)'(2);
    assign y[i*CW+:CW] = s[CW+1:2];
  end
endmodule

// File: rtl/pic_scale_engine.sv
// pic_scale_engine: copies, 2x upscales or 2x downscales a picture into one framebuffer field
module pic_scale_engine import dpa_pkg::*; #(
  parameter int FB_W = 256,
  parameter int ADDR_W = 20,
  parameter int PIX_W = 24
) (
  input logic clk,
  input logic reset,
  input logic start,
  input logic abort,
  input logic [2:0] pic_size,
  input logic phase,
  input logic [ADDR_W-1:0] pic_base,
  input logic [ADDR_W-1:0] fb_base,
  pic_scale_engine_if.master mem,
  output logic busy,
  output logic done,
  output logic err
);
  localparam int LG = $clog2(FB_W);
  state_t state;
  mode_t mode;
  logic ph;
  logic [ADDR_W-1:0] pb, fb;
  logic [LG-1:0] c, j;
  logic [1:0] k;
  logic [PIX_W-1:0] p0, p1, p2, hold, avg;
  logic [ADDR_W-1:0] src_a, fb_a;
  logic last_col, last_row, size_ok;
  function automatic logic [ADDR_W-1:0] lin(input logic [ADDR_W-1:0] base, row, col, input int lg);
    return base + (row << lg) + col;
  endfunction
  // c walks output columns (source columns when upscaling), j walks field rows; k sub-steps a pixel
  always_comb begin
    last_col = c == (mode == MODE_UP ? LG'(FB_W / 2 - 1) : LG'(FB_W - 1));
    last_row = j == LG'(FB_W / 2 - 1);
    size_ok = pic_size == SIZE_HALF || pic_size == SIZE_FULL || pic_size == SIZE_DBL;
    src_a = mode == MODE_DOWN ? lin(pb, ADDR_W'({j, ph, k[1]}), ADDR_W'({c, k[0]}), LG + 1)
          : mode == MODE_UP ? lin(pb, ADDR_W'(j), ADDR_W'(c), LG - 1)
          : lin(pb, ADDR_W'({j, ph}), ADDR_W'(c), LG);
    fb_a = lin(fb, ADDR_W'({j, ph}), mode == MODE_UP ? ADDR_W'({c, k[0]}) : ADDR_W'(c), LG);
  end
  pix_avg4 #(.PIX_W(PIX_W)) u_avg (.a(p0), .b(p1), .c(p2), .d(mem.im_q), .y(avg));
  assign mem.im_a = (state == RD || state == ACC) ? src_a : state == WR ? fb_a : '0;
  assign mem.im_wen = state != WR;
  assign mem.im_d = state != WR ? '0 : mode == MODE_DOWN ? avg : (mode == MODE_UP && k[0]) ? hold : mem.im_q;
  // job sequencer: latches job inputs at start, steps counters, owns the status flags
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      mode <= MODE_COPY;
      ph <= 1'b0;
      pb <= '0;
      fb <= '0;
      c <= '0;
      j <= '0;
      k <= '0;
      p0 <= '0;
      p1 <= '0;
      p2 <= '0;
      hold <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      k <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else
      case (state)
        IDLE:
          if (start) begin
            state <= size_ok ? RD : FIN;
            busy <= size_ok;
            done <= !size_ok;
            err <= !size_ok;
            mode <= pic_size == SIZE_HALF ? MODE_UP : pic_size == SIZE_DBL ? MODE_DOWN : MODE_COPY;
            ph <= phase;
            pb <= pic_base;
            fb <= fb_base;
            c <= '0;
            j <= '0;
            k <= '0;
          end
        RD: begin
          state <= mode == MODE_DOWN ? ACC : WR;
          k <= mode == MODE_DOWN ? 2'd1 : 2'd0;
        end
        ACC: begin
          p0 <= k == 2'd1 ? mem.im_q : p0;
          p1 <= k == 2'd2 ? mem.im_q : p1;
          p2 <= k == 2'd3 ? mem.im_q : p2;
          state <= k == 2'd3 ? WR : ACC;
          k <= k + 2'd1;
        end
        WR:
          if (mode == MODE_UP && !k[0]) begin
            hold <= mem.im_q;
            k <= 2'd1;
          end else begin
            k <= '0;
            c <= last_col ? '0 : c + LG'(1);
            j <= last_col ? j + LG'(1) : j;
            state <= (last_col && last_row) ? FIN : RD;
            busy <= !(last_col && last_row);
            done <= last_col && last_row;
          end
        FIN: begin
          state <= IDLE;
          done <= 1'b0;
          err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule
